// File: rtl/axi3_mem_arbiter_pkg.sv
// axi3_arb_pkg: shared types and source indices for the AXI3 memory arbiter.
//   rd_state_t / wr_state_t : read and write FSM encodings
//   SRC_*                   : bit positions in the read request/grant vectors
//   WR_SRC_*                : bit positions in the write request/grant vectors
package axi3_arb_pkg;

  typedef enum logic {
    RD_IDLE,
    RD_ADDR
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP
  } wr_state_t;

  localparam int SRC_ICACHE   = 0;
  localparam int SRC_DCACHE   = 1;
  localparam int SRC_UNCACHED = 2;

  localparam int NUM_RD_SRC = 3;

  // The write side has no icache port, so it uses its own compact numbering.
  localparam int WR_SRC_DCACHE   = 0;
  localparam int WR_SRC_UNCACHED = 1;

  localparam int NUM_WR_SRC = 2;

endpackage

// File: rtl/axi3_mem_arbiter_if.sv
// AXI3 read and write channel bundles used on every arbiter port.
//   axi3_rd_if : AR + R channels
//   axi3_wr_if : AW + W + B channels
// modport master : side issuing requests (cache controller, or arbiter toward memory)
// modport slave  : side accepting requests (arbiter toward the cache, or the interconnect)
interface axi3_rd_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [3:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;

  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

interface axi3_wr_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [3:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awvalid;
  logic                    awready;

  logic [ID_WIDTH-1:0]     wid;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
           wid, wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
           wid, wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/axi3_mem_arbiter_picker.sv
// axi3_arb_picker: selects one requester and holds a registered one-hot grant.
//   clk, rst : clock, async active-high reset
//   req      : request vector
//   enable   : owning FSM is idle; a new grant is loaded when any req is set
//   grant    : registered one-hot grant, held until the next load
// AXI3_ARB_ROUND_ROBIN_EN defined : round-robin, last grant gets lowest priority
// AXI3_ARB_ROUND_ROBIN_EN undefined: fixed priority, highest index wins
module axi3_arb_picker #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         enable,
  output logic [N-1:0] grant
);

  logic [N-1:0] pick;

`ifdef AXI3_ARB_ROUND_ROBIN_EN
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] pick_idx;

  // Lowest requesting index overall, then overridden by the lowest
  // requesting index above the last grant when there is one.
  always_comb begin
    pick = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (i > int'(ptr))) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
  end

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) pick_idx = PW'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (enable && (|req)) begin
      ptr <= pick_idx;
    end
  end
`else
  always_comb begin
    pick = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        pick    = '0;
        pick[i] = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant <= '0;
    end else if (enable && (|req)) begin
      grant <= pick;
    end
  end

endmodule

// File: rtl/axi3_mem_arbiter.sv
// axi3_mem_arbiter: merges the cache controller's five AXI3 master channels
// into one AXI3 master toward the memory interconnect.
//   clk, rst              : clock, async active-high reset
//   axi3_rd_if_icached    : icache reads (slave)
//   axi3_rd_if_dcached    : dcache line refills (slave)
//   axi3_rd_if_duncached  : uncached reads (slave)
//   axi3_wr_if_dcached    : dcache writebacks (slave)
//   axi3_wr_if_duncached  : uncached writes (slave)
//   axi3_rd_if_mem        : merged read channel (master)
//   axi3_wr_if_mem        : merged write channel (master)
//   rid_err               : sticky, an R or B beat carried an unexpected ID
// AXI3_ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
//
// state   | meaning
// RD_IDLE | no AR in flight; picker loads a grant when any ARVALID is seen
// RD_ADDR | granted source's AR forwarded until ARVALID && ARREADY
// WR_IDLE | no write owner; picker loads a grant when any AWVALID is seen
// WR_ADDR | owner's AW forwarded until handshake
// WR_DATA | owner's W forwarded until the WLAST beat completes
// WR_RESP | B routed to the owner until handshake
module axi3_mem_arbiter
  import axi3_arb_pkg::*;
#(
  parameter int ICACHE_ID   = 0,
  parameter int DCACHE_ID   = 1,
  parameter int UNCACHED_ID = 2,
  parameter int ID_WIDTH    = 4
) (
  input  logic      clk,
  input  logic      rst,
  axi3_rd_if.slave  axi3_rd_if_icached,
  axi3_rd_if.slave  axi3_rd_if_dcached,
  axi3_rd_if.slave  axi3_rd_if_duncached,
  axi3_wr_if.slave  axi3_wr_if_dcached,
  axi3_wr_if.slave  axi3_wr_if_duncached,
  axi3_rd_if.master axi3_rd_if_mem,
  axi3_wr_if.master axi3_wr_if_mem,
  output logic      rid_err
);

  localparam logic [ID_WIDTH-1:0] ID_IC = ID_WIDTH'(ICACHE_ID);
  localparam logic [ID_WIDTH-1:0] ID_DC = ID_WIDTH'(DCACHE_ID);
  localparam logic [ID_WIDTH-1:0] ID_UC = ID_WIDTH'(UNCACHED_ID);

  rd_state_t rd_state;
  wr_state_t wr_state;

  logic [NUM_RD_SRC-1:0] ar_req, rd_grant;
  logic [NUM_WR_SRC-1:0] aw_req, wr_grant;

  logic ar_own_valid;
  logic aw_own_valid, w_own_valid, b_own_ready;
  logic [ID_WIDTH-1:0] wr_own_id;
  logic hit_ic, hit_dc, hit_uc, rd_miss;
  logic b_bad;

  assign ar_req = {axi3_rd_if_duncached.arvalid, axi3_rd_if_dcached.arvalid,
                   axi3_rd_if_icached.arvalid};
  assign aw_req = {axi3_wr_if_duncached.awvalid, axi3_wr_if_dcached.awvalid};

  axi3_arb_picker #(.N(NUM_RD_SRC)) u_rd_picker (
    .clk    (clk),
    .rst    (rst),
    .req    (ar_req),
    .enable (rd_state == RD_IDLE),
    .grant  (rd_grant)
  );

  axi3_arb_picker #(.N(NUM_WR_SRC)) u_wr_picker (
    .clk    (clk),
    .rst    (rst),
    .req    (aw_req),
    .enable (wr_state == WR_IDLE),
    .grant  (wr_grant)
  );

  // ---------------- AR channel ----------------
  always_comb begin
    axi3_rd_if_mem.arid    = axi3_rd_if_icached.arid;
    axi3_rd_if_mem.araddr  = axi3_rd_if_icached.araddr;
    axi3_rd_if_mem.arlen   = axi3_rd_if_icached.arlen;
    axi3_rd_if_mem.arsize  = axi3_rd_if_icached.arsize;
    axi3_rd_if_mem.arburst = axi3_rd_if_icached.arburst;
    ar_own_valid           = 1'b0;
    case (1'b1)
      rd_grant[SRC_UNCACHED]: begin
        axi3_rd_if_mem.arid    = axi3_rd_if_duncached.arid;
        axi3_rd_if_mem.araddr  = axi3_rd_if_duncached.araddr;
        axi3_rd_if_mem.arlen   = axi3_rd_if_duncached.arlen;
        axi3_rd_if_mem.arsize  = axi3_rd_if_duncached.arsize;
        axi3_rd_if_mem.arburst = axi3_rd_if_duncached.arburst;
        ar_own_valid           = axi3_rd_if_duncached.arvalid;
      end
      rd_grant[SRC_DCACHE]: begin
        axi3_rd_if_mem.arid    = axi3_rd_if_dcached.arid;
        axi3_rd_if_mem.araddr  = axi3_rd_if_dcached.araddr;
        axi3_rd_if_mem.arlen   = axi3_rd_if_dcached.arlen;
        axi3_rd_if_mem.arsize  = axi3_rd_if_dcached.arsize;
        axi3_rd_if_mem.arburst = axi3_rd_if_dcached.arburst;
        ar_own_valid           = axi3_rd_if_dcached.arvalid;
      end
      rd_grant[SRC_ICACHE]: begin
        ar_own_valid = axi3_rd_if_icached.arvalid;
      end
      default: ;
    endcase
  end

  assign axi3_rd_if_mem.arvalid       = (rd_state == RD_ADDR) && ar_own_valid;
  assign axi3_rd_if_icached.arready   = (rd_state == RD_ADDR) && rd_grant[SRC_ICACHE]
                                        && axi3_rd_if_mem.arready;
  assign axi3_rd_if_dcached.arready   = (rd_state == RD_ADDR) && rd_grant[SRC_DCACHE]
                                        && axi3_rd_if_mem.arready;
  assign axi3_rd_if_duncached.arready = (rd_state == RD_ADDR) && rd_grant[SRC_UNCACHED]
                                        && axi3_rd_if_mem.arready;

  // ---------------- R channel: routed purely by RID ----------------
  assign hit_ic  = (axi3_rd_if_mem.rid == ID_IC);
  assign hit_dc  = (axi3_rd_if_mem.rid == ID_DC);
  assign hit_uc  = (axi3_rd_if_mem.rid == ID_UC);
  assign rd_miss = !(hit_ic || hit_dc || hit_uc);

  always_comb begin
    axi3_rd_if_icached.rid     = axi3_rd_if_mem.rid;
    axi3_rd_if_icached.rdata   = axi3_rd_if_mem.rdata;
    axi3_rd_if_icached.rresp   = axi3_rd_if_mem.rresp;
    axi3_rd_if_icached.rlast   = axi3_rd_if_mem.rlast;
    axi3_rd_if_dcached.rid     = axi3_rd_if_mem.rid;
    axi3_rd_if_dcached.rdata   = axi3_rd_if_mem.rdata;
    axi3_rd_if_dcached.rresp   = axi3_rd_if_mem.rresp;
    axi3_rd_if_dcached.rlast   = axi3_rd_if_mem.rlast;
    axi3_rd_if_duncached.rid   = axi3_rd_if_mem.rid;
    axi3_rd_if_duncached.rdata = axi3_rd_if_mem.rdata;
    axi3_rd_if_duncached.rresp = axi3_rd_if_mem.rresp;
    axi3_rd_if_duncached.rlast = axi3_rd_if_mem.rlast;

    axi3_rd_if_icached.rvalid   = axi3_rd_if_mem.rvalid && hit_ic;
    axi3_rd_if_dcached.rvalid   = axi3_rd_if_mem.rvalid && hit_dc;
    axi3_rd_if_duncached.rvalid = axi3_rd_if_mem.rvalid && hit_uc;

    // Unknown IDs are sunk so a stray beat cannot stall the interconnect;
    // gating with RVALID keeps RREADY low while the bus is quiet.
    if (hit_ic)      axi3_rd_if_mem.rready = axi3_rd_if_icached.rready;
    else if (hit_dc) axi3_rd_if_mem.rready = axi3_rd_if_dcached.rready;
    else if (hit_uc) axi3_rd_if_mem.rready = axi3_rd_if_duncached.rready;
    else             axi3_rd_if_mem.rready = axi3_rd_if_mem.rvalid;
  end

  // ---------------- AW / W / B: owner multiplex ----------------
  always_comb begin
    axi3_wr_if_mem.awid    = axi3_wr_if_dcached.awid;
    axi3_wr_if_mem.awaddr  = axi3_wr_if_dcached.awaddr;
    axi3_wr_if_mem.awlen   = axi3_wr_if_dcached.awlen;
    axi3_wr_if_mem.awsize  = axi3_wr_if_dcached.awsize;
    axi3_wr_if_mem.awburst = axi3_wr_if_dcached.awburst;
    axi3_wr_if_mem.wid     = axi3_wr_if_dcached.wid;
    axi3_wr_if_mem.wdata   = axi3_wr_if_dcached.wdata;
    axi3_wr_if_mem.wstrb   = axi3_wr_if_dcached.wstrb;
    axi3_wr_if_mem.wlast   = axi3_wr_if_dcached.wlast;
    aw_own_valid           = 1'b0;
    w_own_valid            = 1'b0;
    b_own_ready            = 1'b0;
    wr_own_id              = ID_DC;
    case (1'b1)
      wr_grant[WR_SRC_UNCACHED]: begin
        axi3_wr_if_mem.awid    = axi3_wr_if_duncached.awid;
        axi3_wr_if_mem.awaddr  = axi3_wr_if_duncached.awaddr;
        axi3_wr_if_mem.awlen   = axi3_wr_if_duncached.awlen;
        axi3_wr_if_mem.awsize  = axi3_wr_if_duncached.awsize;
        axi3_wr_if_mem.awburst = axi3_wr_if_duncached.awburst;
        axi3_wr_if_mem.wid     = axi3_wr_if_duncached.wid;
        axi3_wr_if_mem.wdata   = axi3_wr_if_duncached.wdata;
        axi3_wr_if_mem.wstrb   = axi3_wr_if_duncached.wstrb;
        axi3_wr_if_mem.wlast   = axi3_wr_if_duncached.wlast;
        aw_own_valid           = axi3_wr_if_duncached.awvalid;
        w_own_valid            = axi3_wr_if_duncached.wvalid;
        b_own_ready            = axi3_wr_if_duncached.bready;
        wr_own_id              = ID_UC;
      end
      wr_grant[WR_SRC_DCACHE]: begin
        aw_own_valid = axi3_wr_if_dcached.awvalid;
        w_own_valid  = axi3_wr_if_dcached.wvalid;
        b_own_ready  = axi3_wr_if_dcached.bready;
      end
      default: ;
    endcase
  end

  assign axi3_wr_if_mem.awvalid = (wr_state == WR_ADDR) && aw_own_valid;
  assign axi3_wr_if_mem.wvalid  = (wr_state == WR_DATA) && w_own_valid;
  assign axi3_wr_if_mem.bready  = (wr_state == WR_RESP) && b_own_ready;

  assign axi3_wr_if_dcached.awready   = (wr_state == WR_ADDR) && wr_grant[WR_SRC_DCACHE]
                                        && axi3_wr_if_mem.awready;
  assign axi3_wr_if_duncached.awready = (wr_state == WR_ADDR) && wr_grant[WR_SRC_UNCACHED]
                                        && axi3_wr_if_mem.awready;
  assign axi3_wr_if_dcached.wready    = (wr_state == WR_DATA) && wr_grant[WR_SRC_DCACHE]
                                        && axi3_wr_if_mem.wready;
  assign axi3_wr_if_duncached.wready  = (wr_state == WR_DATA) && wr_grant[WR_SRC_UNCACHED]
                                        && axi3_wr_if_mem.wready;
  assign axi3_wr_if_dcached.bvalid    = (wr_state == WR_RESP) && wr_grant[WR_SRC_DCACHE]
                                        && axi3_wr_if_mem.bvalid;
  assign axi3_wr_if_duncached.bvalid  = (wr_state == WR_RESP) && wr_grant[WR_SRC_UNCACHED]
                                        && axi3_wr_if_mem.bvalid;

  assign axi3_wr_if_dcached.bid     = axi3_wr_if_mem.bid;
  assign axi3_wr_if_dcached.bresp   = axi3_wr_if_mem.bresp;
  assign axi3_wr_if_duncached.bid   = axi3_wr_if_mem.bid;
  assign axi3_wr_if_duncached.bresp = axi3_wr_if_mem.bresp;

  // Only one write is ever in flight, so a B carrying any other ID is
  // still handed to the owner but flagged.
  assign b_bad = (wr_state == WR_RESP) && axi3_wr_if_mem.bvalid
                 && (axi3_wr_if_mem.bid != wr_own_id);

  // ---------------- FSMs ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state <= RD_IDLE;
    end else begin
      case (rd_state)
        RD_IDLE: if (|ar_req) rd_state <= RD_ADDR;
        RD_ADDR: if (axi3_rd_if_mem.arvalid && axi3_rd_if_mem.arready) rd_state <= RD_IDLE;
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state <= WR_IDLE;
    end else begin
      case (wr_state)
        WR_IDLE: if (|aw_req) wr_state <= WR_ADDR;
        WR_ADDR: if (axi3_wr_if_mem.awvalid && axi3_wr_if_mem.awready) wr_state <= WR_DATA;
        WR_DATA: if (axi3_wr_if_mem.wvalid && axi3_wr_if_mem.wready && axi3_wr_if_mem.wlast)
                   wr_state <= WR_RESP;
        WR_RESP: if (axi3_wr_if_mem.bvalid && axi3_wr_if_mem.bready) wr_state <= WR_IDLE;
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rid_err <= 1'b0;
    end else if ((axi3_rd_if_mem.rvalid && rd_miss) || b_bad) begin
      rid_err <= 1'b1;
    end
  end

endmodule
